// File: rtl/mic1_mem_serdes_if.sv
// Byte-wide external memory bus between the MIC-1 serdes and the memory side.
interface mic1_mem_serdes_if;
  logic [1:0] bus_cmd;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       bus_strobe;
  logic [7:0] bus_in;
  logic       bus_ack;

  modport master (
    output bus_cmd, bus_out, bus_oe, bus_strobe,
    input  bus_in, bus_ack
  );

  modport slave (
    input  bus_cmd, bus_out, bus_oe, bus_strobe,
    output bus_in, bus_ack
  );
endinterface

// File: rtl/mic1_mem_serdes.sv
// MIC-1 memory serdes: turns word read/write and byte fetch requests into
// strobe/ack qualified byte phases (address bytes LSB first, then data bytes).
module mic1_mem_serdes #(
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        req_wr,
  input  logic        req_rd,
  input  logic        req_fetch,
  input  logic [31:0] mar,
  input  logic [31:0] pc,
  input  logic [31:0] mdr_in,
  output logic [31:0] mdr_out,
  output logic [7:0]  mbr_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  mic1_mem_serdes_if.master bus
);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_FETCH = 2'b11;

  localparam logic [1:0] LAST_ADDR = 2'(ADDR_BYTES - 1);
  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [7:0]  timer;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [23:0] rd_lo;
  logic [1:0]  cmd_q;
  logic        strobe_q;
  logic        done_q;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Transaction FSM with timeout; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      timer    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rd_lo    <= 24'd0;
      cmd_q    <= CMD_IDLE;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      mdr_out  <= 32'd0;
      mbr_out  <= 8'd0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (req_wr || req_rd || req_fetch) begin
            state    <= ADDR;
            busy     <= 1'b1;
            strobe_q <= 1'b1;
            err      <= 1'b0;
            byte_idx <= 2'd0;
            timer    <= 8'd0;
            wdata_q  <= mdr_in;
            if (req_wr) begin
              cmd_q  <= CMD_WRITE;
              addr_q <= mar;
            end else if (req_rd) begin
              cmd_q  <= CMD_READ;
              addr_q <= mar;
            end else begin
              cmd_q  <= CMD_FETCH;
              addr_q <= pc;
            end
          end
        end

        ADDR, WDATA, RDATA: begin
          if (!bus.bus_ack) begin
            // Stalled byte phase: abort without done once the budget is spent.
            if (timer == TIMER_MAX) begin
              err      <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              strobe_q <= 1'b0;
              cmd_q    <= CMD_IDLE;
              byte_idx <= 2'd0;
              timer    <= 8'd0;
            end else begin
              timer <= timer + 8'd1;
            end
          end else begin
            timer <= 8'd0;
            case (state)
              ADDR: begin
                if (byte_idx == LAST_ADDR) begin
                  byte_idx <= 2'd0;
                  state    <= (cmd_q == CMD_WRITE) ? WDATA : RDATA;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                end
              end
              WDATA: begin
                if (byte_idx == 2'd3) begin
                  state    <= DONE;
                  done_q   <= 1'b1;
                  strobe_q <= 1'b0;
                  cmd_q    <= CMD_IDLE;
                  byte_idx <= 2'd0;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                end
              end
              default: begin
                if (cmd_q == CMD_FETCH || byte_idx == 2'd3) begin
                  if (cmd_q == CMD_FETCH) begin
                    mbr_out <= bus.bus_in;
                  end else begin
                    mdr_out <= {bus.bus_in, rd_lo};
                  end
                  state    <= DONE;
                  done_q   <= 1'b1;
                  strobe_q <= 1'b0;
                  cmd_q    <= CMD_IDLE;
                  byte_idx <= 2'd0;
                end else begin
                  case (byte_idx)
                    2'd0:    rd_lo[7:0]   <= bus.bus_in;
                    2'd1:    rd_lo[15:8]  <= bus.bus_in;
                    default: rd_lo[23:16] <= bus.bus_in;
                  endcase
                  byte_idx <= byte_idx + 2'd1;
                end
              end
            endcase
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          strobe_q <= 1'b0;
          done_q   <= 1'b0;
          cmd_q    <= CMD_IDLE;
        end
      endcase
    end
  end

  // Outgoing byte select: address bytes in ADDR, write data bytes in WDATA.
  always_comb begin
    bus.bus_out = 8'd0;
    bus.bus_oe  = 1'b0;
    case (state)
      ADDR: begin
        bus.bus_out = byte_sel(addr_q, byte_idx);
        bus.bus_oe  = 1'b1;
      end
      WDATA: begin
        bus.bus_out = byte_sel(wdata_q, byte_idx);
        bus.bus_oe  = 1'b1;
      end
      default: begin
        bus.bus_out = 8'd0;
        bus.bus_oe  = 1'b0;
      end
    endcase
  end

  // ena gates the handshake strobe and the done pulse immediately.
  assign bus.bus_strobe = strobe_q & ena;
  assign bus.bus_cmd    = cmd_q;
  assign done           = done_q & ena;

endmodule

// File: doc/mic1_mem_serdes.md
Name: mic1_mem_serdes

Overview:
- Byte-serial memory interface between the MIC-1 datapath (MAR/MDR/PC/MBR) and the 8-bit external pins.
- Converts 32-bit word read/write requests and byte opcode fetches into a byte-wide transaction: address bytes, then data bytes, each qualified by a strobe/ack handshake.
- Returns the assembled read word for MDR or the fetched byte for MBR, and pulses done.

Parameters:
- ADDR_BYTES, 4, number of address bytes sent per transaction (1..4), LSB first.
- TIMEOUT, 255, idle cycles without ack in any byte phase before abort (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- ena  in  1  global enable; low freezes all state
- req_wr  in  1  write mdr_in to word address mar
- req_rd  in  1  read word at mar into mdr_out
- req_fetch  in  1  read byte at pc into mbr_out
- mar  in  32  word-access address
- pc  in  32  fetch address
- mdr_in  in  32  write data
- mdr_out  out  32  last read word
- mbr_out  out  8  last fetched byte
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag
- bus_cmd  out  2  00 idle, 01 read, 10 write, 11 fetch; stable for whole transaction
- bus_out  out  8  outgoing address/write byte
- bus_oe  out  1  1 while block drives bus_out (ADDR, WDATA)
- bus_strobe  out  1  byte phase active
- bus_in  in  8  incoming read byte
- bus_ack  in  1  external side accepts/supplies byte this cycle

Behaviour:
- Reset: state IDLE; byte_idx 0; timer 0; all outputs 0 (mdr_out, mbr_out, busy, done, err, bus_*).
- ena=0: no state, counter, register or timer change; bus_strobe forced 0; done forced 0.
- States: IDLE, ADDR, WDATA, RDATA, DONE.
- IDLE: requests sampled only here; requests while busy are ignored, not queued.
  - Priority when several are high: wr > rd > fetch; losers are dropped.
  - On accept: latch address (mar, or pc for fetch) and mdr_in; set bus_cmd; clear err; byte_idx 0; go ADDR.
- Transfer rule: a byte moves on a rising edge where ena & bus_strobe & bus_ack. bus_strobe is 1 in ADDR/WDATA/RDATA.
- ADDR: bus_out = addr byte[byte_idx]; after byte ADDR_BYTES-1 transfers, byte_idx reset to 0.
  - Then go WDATA (wr), RDATA (rd, fetch).
- WDATA: bus_out = wdata byte[byte_idx], bytes 0..3; after byte 3 go DONE.
- RDATA: bus_oe 0.
  - Read: bus_in stored into shift register byte[byte_idx]; after byte 3, mdr_out loads the full word; go DONE.
  - Fetch: 1 byte only; mbr_out <= bus_in; go DONE.
- DONE: done=1 for exactly one cycle; bus_cmd cleared; go IDLE. Next request is acceptable in the cycle after DONE.
- mdr_out/mbr_out change only at a successful completion and hold otherwise; never partially updated.
- Latency with bus_ack held high, ADDR_BYTES=4, request seen at edge T:
  - Read or write: done high in cycle T+9.
  - Fetch: done high in cycle T+6.
- Timeout: timer counts cycles with strobe & !ack while ena=1; it clears on every transfer.
  - When timer reaches TIMEOUT: err<=1, no done, outputs unchanged, go IDLE.
- Reset mid-transaction: IDLE next cycle, strobe low, registers cleared; no done.
- Address bytes above ADDR_BYTES are not transmitted. Internal byte_idx wraps only via explicit reset, never past 3.

Test Plan:
- Read, ack always 1, mar=0x00000010, bus_in bytes 0x78,0x56,0x34,0x12 → bus_out 10,00,00,00 (oe=1, cmd=01), done at T+9, mdr_out=0x12345678.
- Write, mar=0xA0B0C0D0, mdr_in=0xDEADBEEF, ack always 1 → bus_out sequence D0,C0,B0,A0,EF,BE,AD,DE, cmd=10, done at T+9, mdr_out unchanged.
- Fetch, pc=0x00000003, bus_in 0x59, ack delayed 3 cycles on every byte → mbr_out=0x59, done exactly once, busy high throughout.
- req_wr, req_rd and req_fetch high together → only write executes; req_rd raised mid-transaction → ignored, no second done.
- TIMEOUT=4, ack held 0 in RDATA → err=1 after 4 stalled cycles, state IDLE, no done, mdr_out unchanged; next request clears err.
- ena low for 5 cycles mid-ADDR, then rst_n low mid-RDATA → frozen byte_idx and bus_out while ena low; after reset all outputs 0, busy 0.
